// File: rtl/text_display_pkg.sv
// Shared constants, FSM encoding and glyph addressing
// for the text display pixel path.
package text_display_pkg;

  localparam int COLS                 = 80;
  localparam int ROWS                 = 60;
  localparam int CELL_LINES           = 8;
  localparam int GLYPH_WORDS_PER_CHAR = 4;
  localparam int GLYPH_NAT_W          = 10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_TEXT    = 3'd1,
    WAIT_TEXT  = 3'd2,
    RD_GLYPH   = 3'd3,
    WAIT_GLYPH = 3'd4,
    PUSH       = 3'd5
  } fetch_state_e;

  // Four 16-bit words per glyph, two scanlines per word.
  function automatic logic [GLYPH_NAT_W-1:0] glyph_addr_f(
    input logic [7:0] code,
    input logic [2:0] lic
  );
    glyph_addr_f = {code, 2'b00} + {8'd0, lic[2:1]};
  endfunction

endpackage

// File: rtl/glyph_pixel_buffer.sv
// Two-slot glyph byte buffer with MSB-first pixel shifter
// and valid/ready output handshake.
module glyph_pixel_buffer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       wr_en,
  input  logic [7:0] wr_byte,
  output logic       full,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_on,
  output logic       slot_free
);

  logic [1:0][7:0] slot_q, slot_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic            accept;
  logic            do_wr;

  assign full      = (cnt_q == 2'd2);
  assign pix_valid = (cnt_q != 2'd0);
  assign pix_on    = slot_q[rd_ptr_q][3'd7 - bit_q];
  assign accept    = pix_valid && pix_ready;
  assign slot_free = accept && (bit_q == 3'd7);
  assign do_wr     = wr_en && !full;

  // Slot write, pixel advance and occupancy update.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
      bit_d    = 3'd0;
    end else begin
      if (do_wr) begin
        slot_d[wr_ptr_q] = wr_byte;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (accept) begin
        bit_d = bit_q + 3'd1;
      end
      if (slot_free) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_wr, slot_free})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      bit_q    <= 3'd0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
    end
  end

endmodule

// File: rtl/glyph_fetch_sequencer.sv
// Per-scanline text/glyph fetch FSM feeding the
// pixel buffer; one character every five cycles.
module glyph_fetch_sequencer #(
  parameter  int COLS     = text_display_pkg::COLS,
  parameter  int ROWS     = text_display_pkg::ROWS,
  parameter  int TEXT_AW  = 13,
  parameter  int GLYPH_AW = 13,
  localparam int ROW_W    = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic [ROW_W-1:0]    row_index,
  input  logic [2:0]          line_in_cell,
  output logic                text_rd,
  output logic [TEXT_AW-1:0]  text_addr,
  input  logic [7:0]          text_data,
  output logic                glyph_rd,
  output logic [GLYPH_AW-1:0] glyph_addr,
  input  logic [15:0]         glyph_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_on,
  output logic                line_done,
  output logic                overrun
);

  import text_display_pkg::*;

  localparam int CW = $clog2(COLS + 1);

  fetch_state_e       state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [TEXT_AW-1:0] row_base_q, row_base_d;
  logic [2:0]         lic_q, lic_d;
  logic [GLYPH_AW-1:0] gaddr_q, gaddr_d;
  logic [7:0]         byte_q, byte_d;
  logic [CW-1:0]      done_cnt_q, done_cnt_d;
  logic               line_done_q, line_done_d;
  logic               overrun_q, overrun_d;

  logic               busy;
  logic               flush;
  logic               buf_wr;
  logic               buf_full;
  logic               slot_free;

  assign busy       = (state_q != IDLE) || pix_valid;
  assign flush      = line_start && busy;
  assign buf_wr     = (state_q == PUSH) && !line_start;
  assign text_rd    = (state_q == RD_TEXT);
  assign glyph_rd   = (state_q == RD_GLYPH);
  assign text_addr  = text_rd
                    ? row_base_q + TEXT_AW'(col_q)
                    : '0;
  assign glyph_addr = gaddr_q;
  assign line_done  = line_done_q;
  assign overrun    = overrun_q;

  // Fetch FSM, address generation and line bookkeeping.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_base_d  = row_base_q;
    lic_d       = lic_q;
    gaddr_d     = gaddr_q;
    byte_d      = byte_q;
    done_cnt_d  = done_cnt_q;
    line_done_d = 1'b0;
    overrun_d   = overrun_q | flush;
    if (line_start) begin
      row_base_d = TEXT_AW'(row_index) * TEXT_AW'(COLS);
      lic_d      = line_in_cell;
      col_d      = '0;
      done_cnt_d = '0;
      state_d    = RD_TEXT;
    end else begin
      if (slot_free) begin
        done_cnt_d  = done_cnt_q + CW'(1);
        line_done_d = (done_cnt_q == CW'(COLS - 1));
      end
      unique case (state_q)
        IDLE: ;
        RD_TEXT:
          state_d = WAIT_TEXT;
        WAIT_TEXT: begin
          gaddr_d = GLYPH_AW'(glyph_addr_f(text_data, lic_q));
          state_d = RD_GLYPH;
        end
        RD_GLYPH:
          state_d = WAIT_GLYPH;
        WAIT_GLYPH: begin
          unique case (1'b1)
            lic_q[0]:  byte_d = glyph_data[7:0];
            !lic_q[0]: byte_d = glyph_data[15:8];
          endcase
          state_d = PUSH;
        end
        PUSH: begin
          if (!buf_full) begin
            if (col_q == CW'(COLS - 1)) begin
              col_d   = '0;
              state_d = IDLE;
            end else begin
              col_d   = col_q + CW'(1);
              state_d = RD_TEXT;
            end
          end
        end
        default:
          state_d = IDLE;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_base_q  <= '0;
      lic_q       <= '0;
      gaddr_q     <= '0;
      byte_q      <= '0;
      done_cnt_q  <= '0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_base_q  <= row_base_d;
      lic_q       <= lic_d;
      gaddr_q     <= gaddr_d;
      byte_q      <= byte_d;
      done_cnt_q  <= done_cnt_d;
      line_done_q <= line_done_d;
      overrun_q   <= overrun_d;
    end
  end

  glyph_pixel_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wr_en     (buf_wr),
    .wr_byte   (byte_q),
    .full      (buf_full),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_on    (pix_on),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_glyph_fetch_sequencer.sv
// Scoreboard bench for glyph_fetch_sequencer: text RAM
// and glyph ROM models, pixel/address queues, monitors.
module tb_glyph_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [5:0]  row_index;
  logic [2:0]  line_in_cell;
  logic        text_rd;
  logic [12:0] text_addr;
  logic [7:0]  text_data = 8'd0;
  logic        glyph_rd;
  logic [12:0] glyph_addr;
  logic [15:0] glyph_data = 16'd0;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_on;
  logic        line_done;
  logic        overrun;

  logic [7:0]  text_mem  [0:8191];
  logic [15:0] glyph_mem [0:8191];

  bit pix_q[$];
  int addr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc_cyc = -10;
  int done_cnt = 0;
  int gap_cnt = 0;
  bit gap_chk = 1'b0;
  bit seen_first = 1'b0;
  bit bp = 1'b0;

  glyph_fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_start   (line_start),
    .row_index    (row_index),
    .line_in_cell (line_in_cell),
    .text_rd      (text_rd),
    .text_addr    (text_addr),
    .text_data    (text_data),
    .glyph_rd     (glyph_rd),
    .glyph_addr   (glyph_addr),
    .glyph_data   (glyph_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_on       (pix_on),
    .line_done    (line_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (text_rd) text_data <= text_mem[text_addr];
    if (glyph_rd) glyph_data <= glyph_mem[glyph_addr];
  end

  // Consumer ready pattern, changed away from the edge.
  always @(posedge clk) begin
    #2;
    pix_ready = bp ? ((cyc % 3) == 0) : 1'b1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Pixel / line_done / address monitor.
  always @(negedge clk) begin
    chk("strobe_excl", {31'd0, text_rd & glyph_rd}, 32'd0);
    if (text_rd) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_text_rd: addr %0d", text_addr);
      end else begin
        chk("text_addr", {19'd0, text_addr}, addr_q.pop_front());
      end
    end
    if (gap_chk && seen_first && !pix_valid
        && pix_q.size() > 0)
      gap_cnt++;
    if (pix_valid) seen_first = 1'b1;
    if (line_done) begin
      done_cnt++;
      chk("done_timing", last_acc_cyc, cyc - 1);
      chk("done_queue_empty", pix_q.size(), 0);
    end
    if (pix_valid && pix_ready) begin
      acc_cnt++;
      last_acc_cyc = cyc;
      if (pix_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %0b expected none",
                 pix_on);
      end else begin
        chk("pix_on", {31'd0, pix_on}, {31'd0, pix_q.pop_front()});
      end
    end
  end

  task automatic push_line(input int row, input logic [2:0] lic);
    for (int c = 0; c < 80; c++) begin
      int a;
      logic [9:0]  g;
      logic [15:0] w;
      logic [7:0]  b;
      a = row * 80 + c;
      addr_q.push_back(a);
      g = {text_mem[a], 2'b00} + {8'd0, lic[2:1]};
      w = glyph_mem[g];
      b = lic[0] ? w[7:0] : w[15:8];
      for (int k = 7; k >= 0; k--) pix_q.push_back(b[k]);
    end
  endtask

  // Pulse line_start; returns #1 into cycle 1 of the line.
  task automatic start_line(input int row, input logic [2:0] lic);
    @(posedge clk);
    #2;
    line_start = 1'b1;
    row_index = 6'(row);
    line_in_cell = lic;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    pix_q.delete();
    addr_q.delete();
    push_line(row, lic);
    acc_cnt = 0;
    seen_first = 1'b0;
  endtask

  task automatic wait_done(input int exp);
    int t;
    t = 0;
    while (done_cnt < exp && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("line_done_count", done_cnt, exp);
    chk("pixels_left", pix_q.size(), 0);
    chk("addrs_left", addr_q.size(), 0);
  endtask

  initial begin
    logic [7:0] pat;
    int t;
    rst_n = 1'b0;
    line_start = 1'b0;
    row_index = '0;
    line_in_cell = '0;
    pix_ready = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      text_mem[i] = 8'((i * 37 + 11) & 255);
      glyph_mem[i] = 16'((i * 40503) ^ (i << 5));
    end
    text_mem[160] = 8'h41;
    glyph_mem[13'h106] = 16'h3C81;

    // 1: reset state
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("reset_outputs",
          {text_rd, glyph_rd, pix_valid, line_done, overrun,
           text_addr, glyph_addr}, 32'd0);
    end

    // 2/3: first line, hand-checked latency and pixels
    gap_chk = 1'b1;
    start_line(2, 3'd5);
    chk("c1_text_rd", {31'd0, text_rd}, 1);
    chk("c1_text_addr", {19'd0, text_addr}, 160);
    @(posedge clk); #1;
    chk("c2_strobes", {30'd0, text_rd, glyph_rd}, 0);
    @(posedge clk); #1;
    chk("c3_glyph_rd", {31'd0, glyph_rd}, 1);
    chk("c3_glyph_addr", {19'd0, glyph_addr}, 32'h106);
    @(posedge clk); #1;
    chk("c4_pix_valid", {31'd0, pix_valid}, 0);
    @(posedge clk); #1;
    chk("c5_pix_valid", {31'd0, pix_valid}, 0);
    @(posedge clk); #1;
    chk("c6_pix_valid", {31'd0, pix_valid}, 1);
    pat = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      chk("hand_pixel", {31'd0, pix_on}, {31'd0, pat[7 - i]});
      @(posedge clk); #1;
    end
    wait_done(1);
    chk("accepted_640", acc_cnt, 640);
    chk("no_valid_gap", gap_cnt, 0);
    chk("overrun_clear", {31'd0, overrun}, 0);

    // 4: backpressure, one ready cycle in three
    gap_chk = 1'b0;
    bp = 1'b1;
    start_line(5, 3'd2);
    wait_done(2);
    chk("bp_accepted_640", acc_cnt, 640);
    bp = 1'b0;

    // 5: overrun at cycle 100 of a line
    start_line(10, 3'd3);
    repeat (98) @(posedge clk);
    start_line(11, 3'd6);
    chk("overrun_set", {31'd0, overrun}, 1);
    chk("flushed_valid", {31'd0, pix_valid}, 0);
    chk("restart_addr", {19'd0, text_addr}, 880);
    wait_done(3);
    chk("ovr_accepted_640", acc_cnt, 640);
    chk("overrun_sticky", {31'd0, overrun}, 1);

    // 6: reset at pixel 300
    start_line(20, 3'd1);
    t = 0;
    while (acc_cnt < 300 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("reached_pix_300", acc_cnt, 300);
    #2;
    rst_n = 1'b0;
    pix_q.delete();
    addr_q.delete();
    #1;
    chk("rst_pix_valid", {31'd0, pix_valid}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet",
          {29'd0, pix_valid, text_rd, glyph_rd}, 0);
    end
    start_line(21, 3'd7);
    wait_done(4);
    chk("rst_accepted_640", acc_cnt, 640);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/glyph_fetch_sequencer.md
Name: glyph_fetch_sequencer

Overview:
- Per-scanline sequencer for the text display pixel path.
- On each active-line start it walks the character columns of the current text row and reads each ASCII code from the text RAM.
- It forms the glyph ROM word address from the code, fetches the 16-bit glyph word, and selects the byte for the current scanline.
- It streams the 8 pixels of each character to the display serializer over a valid/ready handshake. It sits between the VGA timing generator, the text RAM, the glyph ROM and the pixel output stage.

Parameters:
- COLS, 80, character columns per text row.
- ROWS, 60, text rows per frame (8 scanlines each).
- TEXT_AW, 13, text RAM address width; must hold ROWS*COLS-1.
- GLYPH_AW, 13, glyph ROM word address width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse at the start of each active scanline.
- row_index  in  6  text row of the scanline, 0..ROWS-1; sampled with line_start.
- line_in_cell  in  3  scanline within the 8-line cell; sampled with line_start.
- text_rd  out  1  text RAM read strobe.
- text_addr  out  TEXT_AW  text RAM address = row_index*COLS + col.
- text_data  in  8  ASCII code; valid the cycle after text_rd.
- glyph_rd  out  1  glyph ROM read strobe.
- glyph_addr  out  GLYPH_AW  glyph ROM word address.
- glyph_data  in  16  glyph word; valid the cycle after glyph_rd; [15:8] even line, [7:0] odd line.
- pix_valid  out  1  pix_on is valid.
- pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready.
- pix_on  out  1  foreground (1) or background (0) pixel.
- line_done  out  1  one-cycle pulse after the last pixel of the line is accepted.
- overrun  out  1  sticky flag: line_start arrived while a line was still in progress.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, col=0, buffer empty, overrun cleared. Reset mid-line aborts the line immediately; no partial pixels are emitted after release.
- Glyph address, zero-extended to GLYPH_AW: glyph_addr = {ASCII,2'b00} + line_in_cell[2:1]. Byte select: line_in_cell[0]=0 takes [15:8], 1 takes [7:0]. Pixel order is MSB first.
- FSM states: IDLE, RD_TEXT, WAIT_TEXT, RD_GLYPH, WAIT_GLYPH, PUSH.
  - IDLE: on line_start, latch row_base = row_index*COLS and line_in_cell; col=0; go to RD_TEXT.
  - RD_TEXT: text_rd=1 for one cycle, text_addr = row_base+col, then WAIT_TEXT.
  - WAIT_TEXT: capture text_data, then RD_GLYPH.
  - RD_GLYPH: glyph_rd=1 for one cycle with the registered glyph_addr, then WAIT_GLYPH.
  - WAIT_GLYPH: capture the selected byte, then PUSH.
  - PUSH: write the byte into the 2-entry byte buffer when it has a free slot, otherwise stall in PUSH. After the write, col+1. If col was COLS-1, go to IDLE; else go to RD_TEXT.
- Fetch cadence: 5 cycles per character, so the next fetch proceeds while the current byte drains.
- Pixel buffer: 2 byte slots plus a 3-bit bit index.
  - pix_valid = buffer non-empty.
  - On accept, the bit index advances; after bit 7 the slot is freed.
  - A write and a free in the same cycle are both honoured.
- Latency: line_start at edge 0 gives text_rd high in cycle 1 and glyph_rd high in cycle 3. The first pix_valid is high in cycle 6 (after the PUSH write at edge 5).
- Sustained rate: 8 pixels/char against 5 fetch cycles/char, so with pix_ready held at 1 pix_valid never drops between characters after the first.
- line_done pulses the cycle after the COLS*8-th pixel is accepted.
- line_start while the FSM is not IDLE, or the buffer is non-empty: set overrun, flush the buffer, restart from col 0 with the new row/line. overrun clears only on reset.
- text_rd and glyph_rd are never high in the same cycle.
- row_index ≥ ROWS: address computed as-is; behaviour is outside specification.

Decomposition:
- Shared package text_display_pkg holds:
  - COLS, ROWS, CELL_LINES=8, GLYPH_WORDS_PER_CHAR=4;
  - the FSM state encoding;
  - the glyph address function.
- One natural sub-module: glyph_pixel_buffer, the 2-slot byte buffer with pixel shifter and valid/ready logic.
- The FSM and address generation stay in the top.

Test Plan:
1. Reset check: rst_n low, then high → all outputs 0 and no strobes until line_start.
2. Line fetch: line_start, row_index=2, line_in_cell=5; text RAM col0='A'(0x41); glyph_data=0x3C81; pix_ready=1.
   - text_addr=160 in cycle 1; glyph_addr=0x106 in cycle 3.
   - pixels 1,0,0,0,0,0,0,1 starting in cycle 6.
3. Full line, pix_ready=1, COLS=80 → exactly 640 accepted pixels, no pix_valid gap after the first, text_addr 160..239, one line_done.
4. Backpressure: pix_ready toggling 1-of-3 cycles → FSM stalls in PUSH, no pixel lost or duplicated, order matches the model.
5. Overrun: second line_start at cycle 100 of a line → overrun=1, buffer flushed, next text_addr = new row_base+0.
6. Reset mid-line: rst_n low at pixel 300 → pix_valid=0 immediately. After release, nothing is emitted until line_start, then a normal line.
